// File: rtl/heading_servo_driver.sv
// Turns per-frame heading/no-red reports into a slew-limited hobby-servo PWM.
// Returns the servo to centre after LOST_FRAMES consecutive frames without a target.
module heading_servo_driver #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned FOV         = 25,
  parameter int unsigned PERIOD_US   = 20000,
  parameter int unsigned MIN_US      = 1000,
  parameter int unsigned MAX_US      = 2000,
  parameter int unsigned CENTRE_US   = 1500,
  parameter int unsigned STEP_US     = 20,
  parameter int unsigned LOST_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_done,
  input  logic [4:0]  direction,
  input  logic        no_red,
  output logic        servo_pwm,
  output logic [11:0] pulse_us,
  output logic        tracking,
  output logic [1:0]  state
);

  localparam int unsigned PRESC   = CLK_HZ / 1000000;
  localparam int unsigned PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int unsigned US_W    = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int unsigned LOST_W  = $clog2(LOST_FRAMES + 1);
  localparam int unsigned PW      = 12;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOST   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [US_W-1:0]     us_cnt_q, us_cnt_d;
  logic                pwm_q, pwm_d;
  logic [PW-1:0]       pulse_us_q, pulse_us_d;
  logic [PW-1:0]       target_q, target_d;
  logic [LOST_W-1:0]   lost_cnt_q, lost_cnt_d;
  logic                tracking_q, tracking_d;
  logic                evt_q, evt_d;
  logic [PW-1:0]       map_q, map_d;
  logic                nored_q, nored_d;

  logic                us_tick_c;
  logic                period_start_c;
  logic [31:0]         dir_clamped_c;
  logic [PW-1:0]       map_c;
  logic                lost_expire_c;
  logic                slew_up_c;
  logic [PW-1:0]       slew_diff_c;
  logic [PW-1:0]       slew_c;

  // Microsecond prescaler and PWM period counter
  always_comb begin
    us_tick_c      = (presc_q == PRESC_W'(PRESC - 1));
    period_start_c = us_tick_c && (us_cnt_q == US_W'(PERIOD_US - 1));
    presc_d        = us_tick_c ? '0 : presc_q + PRESC_W'(1);
    us_cnt_d       = us_cnt_q;
    if (us_tick_c) begin
      us_cnt_d = period_start_c ? '0 : us_cnt_q + US_W'(1);
    end
    pwm_d = (32'(us_cnt_q) < 32'(pulse_us_q));
  end

  // Heading-to-pulse mapping, captured one cycle after the frame strobe
  always_comb begin
    dir_clamped_c = (32'(direction) > FOV) ? 32'(FOV) : 32'(direction);
    map_c         = PW'(MIN_US + (dir_clamped_c * (MAX_US - MIN_US)) / FOV);
    evt_d         = frame_done;
    map_d         = frame_done ? map_c : map_q;
    nored_d       = frame_done ? no_red : nored_q;
  end

  assign lost_expire_c = ((32'(lost_cnt_q) + 32'd1) == LOST_FRAMES);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; frame reports arrive through the mapping register
  always_comb begin
    state_d = state_q;
    if (evt_q) begin
      case (state_q)
        ST_SEARCH: begin
          if (!nored_q) state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (nored_q) state_d = (LOST_FRAMES <= 1) ? ST_SEARCH : ST_LOST;
        end
        ST_LOST: begin
          if (!nored_q) begin
            state_d = ST_TRACK;
          end else if (lost_expire_c) begin
            state_d = ST_SEARCH;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // FSM outputs: target pulse width, lost-frame counter, tracking flag
  always_comb begin
    target_d   = target_q;
    lost_cnt_d = lost_cnt_q;
    tracking_d = (state_d != ST_SEARCH);
    if (evt_q) begin
      case (state_q)
        ST_SEARCH: begin
          target_d   = nored_q ? PW'(CENTRE_US) : map_q;
          lost_cnt_d = '0;
        end
        ST_TRACK: begin
          if (!nored_q) begin
            target_d = map_q;
          end else if (LOST_FRAMES <= 1) begin
            target_d   = PW'(CENTRE_US);
            lost_cnt_d = '0;
          end else begin
            lost_cnt_d = LOST_W'(1);
          end
        end
        ST_LOST: begin
          if (!nored_q) begin
            target_d   = map_q;
            lost_cnt_d = '0;
          end else if (lost_expire_c) begin
            target_d   = PW'(CENTRE_US);
            lost_cnt_d = '0;
          end else begin
            lost_cnt_d = lost_cnt_q + LOST_W'(1);
          end
        end
        default: begin
          target_d   = PW'(CENTRE_US);
          lost_cnt_d = '0;
        end
      endcase
    end
  end

  // Slew limiter; pulse width only moves at the start of a PWM period
  always_comb begin
    slew_up_c   = (target_q > pulse_us_q);
    slew_diff_c = slew_up_c ? (target_q - pulse_us_q) : (pulse_us_q - target_q);
    if (32'(slew_diff_c) <= STEP_US) begin
      slew_c = target_q;
    end else if (slew_up_c) begin
      slew_c = pulse_us_q + PW'(STEP_US);
    end else begin
      slew_c = pulse_us_q - PW'(STEP_US);
    end
    pulse_us_d = period_start_c ? slew_c : pulse_us_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      us_cnt_q   <= '0;
      pwm_q      <= 1'b0;
      pulse_us_q <= PW'(CENTRE_US);
      target_q   <= PW'(CENTRE_US);
      lost_cnt_q <= '0;
      tracking_q <= 1'b0;
      evt_q      <= 1'b0;
      map_q      <= PW'(CENTRE_US);
      nored_q    <= 1'b1;
    end else begin
      presc_q    <= presc_d;
      us_cnt_q   <= us_cnt_d;
      pwm_q      <= pwm_d;
      pulse_us_q <= pulse_us_d;
      target_q   <= target_d;
      lost_cnt_q <= lost_cnt_d;
      tracking_q <= tracking_d;
      evt_q      <= evt_d;
      map_q      <= map_d;
      nored_q    <= nored_d;
    end
  end

  assign servo_pwm = pwm_q;
  assign pulse_us  = pulse_us_q;
  assign tracking  = tracking_q;
  assign state     = state_q;

endmodule

// File: doc/heading_servo_driver.md
Name: heading_servo_driver

Overview:
- Sits directly downstream of the red-object direction detector. Once per frame it takes the detector's 0..FOV heading and no-red flag and turns them into a servo target.
- It slew-limits the target and generates a standard hobby-servo PWM signal for the turret/head servo.
- When the target is lost for a set number of frames, it returns the servo to centre.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- FOV, 25, maximum heading code (camera FOV in degrees); heading 0 is the left edge, FOV is the right edge.
- PERIOD_US, 20000, PWM period in microseconds.
- MIN_US, 1000, pulse width for heading 0.
- MAX_US, 2000, pulse width for heading FOV.
- CENTRE_US, 1500, pulse width used at reset and in SEARCH.
- STEP_US, 20, maximum pulse-width change per PWM period (slew limit).
- LOST_FRAMES, 30, consecutive no-red frames before returning to centre.

Ports:
- clk, input, 1, 50 MHz system clock.
- rst_n, input, 1, asynchronous active-low reset.
- frame_done, input, 1, single-cycle strobe; direction and no_red are valid for the new frame.
- direction, input, 5, unsigned heading from the detector.
- no_red, input, 1, 1 means no object was detected this frame.
- servo_pwm, output, 1, registered PWM output to the servo.
- pulse_us, output, 12, pulse width currently being driven, in microseconds.
- tracking, output, 1, high in TRACK and LOST states.
- state, output, 2, current FSM state: SEARCH=0, TRACK=1, LOST=2.

Behaviour:
- Reset (async assert, all values take effect immediately):
  - servo_pwm=0, pulse_us=CENTRE_US, target=CENTRE_US, state=SEARCH, tracking=0.
  - Microsecond prescaler, period counter and lost counter all 0.
- Timebase:
  - Prescaler counts 0..CLK_HZ/1000000-1 and emits us_tick on wrap.
  - Period counter us_cnt advances on us_tick over 0..PERIOD_US-1, then wraps.
  - period_start is asserted in the cycle where us_cnt wraps to 0.
- PWM:
  - servo_pwm <= (us_cnt < pulse_us), registered.
  - pulse_us changes only at period_start, so pulses are never truncated or stretched mid-period.
- Target mapping (on frame_done):
  - d = min(direction, FOV).
  - Candidate target = MIN_US + (d*(MAX_US-MIN_US))/FOV, integer division truncated, 12-bit result.
  - Result is registered 1 cycle after frame_done (combinational multiply/divide allowed, one pipeline register).
- FSM, evaluated on frame_done only:
  - SEARCH: no_red=0 -> TRACK, target=mapped value. no_red=1 -> stay, target=CENTRE_US.
  - TRACK: no_red=0 -> stay, target=mapped value. no_red=1 -> LOST, lost_cnt=1, target unchanged.
  - LOST: no_red=0 -> TRACK, lost_cnt=0, target=mapped value. no_red=1 -> lost_cnt+1; when lost_cnt+1 == LOST_FRAMES -> SEARCH, target=CENTRE_US, lost_cnt=0.
  - LOST_FRAMES=1 means the first no-red frame in TRACK goes straight to SEARCH.
- Slew (at period_start):
  - delta = target - pulse_us, signed 13-bit.
  - If |delta| <= STEP_US: pulse_us=target. Otherwise pulse_us += sign(delta)*STEP_US.
  - pulse_us never leaves [MIN_US, MAX_US] ∪ {CENTRE_US}.
- Simultaneous events:
  - frame_done coinciding with period_start: the slew uses the old target; the new target applies from the next period.
  - Two frame_done strobes within one period: the last one wins.
  - frame_done one cycle after another while the mapping register is pending: the later value overwrites.
- Reset mid-operation: all state returns to reset values immediately (async). The first full period begins on the first clk edge after rst_n deasserts, with a CENTRE_US pulse.
- Counter widths derive from CLK_HZ and PERIOD_US; no counter wraps other than the prescaler and the period counter.

Test Plan:
- Reset release, no frame_done for 3 periods -> servo_pwm high exactly 1500 us (75000 clk) of every 20000 us; state=0; tracking=0.
- One frame_done with direction=25, no_red=0 -> state=1; pulse_us goes 1520, 1540, … reaching 2000 after 25 periods, then holds.
- direction=12 then direction=0 (each with no_red=0) -> target 1480, then 1000; pulse_us moves down 20 per period; direction=31 maps to 2000 (clamped).
- From TRACK at 2000: 29 frames with no_red=1 -> state=2, pulse_us stays 2000. 30th frame -> state=0, target 1500, pulse_us decreases 20 per period to 1500. A no_red=0 frame at the 15th lost frame instead -> state=1, lost_cnt cleared.
- frame_done with direction=0 on the same cycle as period_start, from 1500 -> that period still uses the old target (pulse 1500); the next period is 1480.
- rst_n pulsed low mid-pulse while pulse_us=1800 -> servo_pwm=0 within the same cycle; after release, pulse_us=1500 and state=0.
